// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states, default width.
// Divide support is enabled by defining MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // op[1] selects divide, op[0] selects the unsigned flavour
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side issue/result bundle of the multiply/divide unit.
// The pipeline drives through the master modport; the unit uses the slave modport.
interface ex_muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, rs, rt, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output hi, lo, busy, stall, done
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Final two's-complement correction of the {HI,LO} magnitude pair produced by the iterative core.
// Divide-specific selection (quotient/remainder signs, divide-by-zero) exists only with MULDIV_DIV_EN.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic               is_div_i,
  input  logic               rem_neg_i,
  input  logic               div0_i,
  input  logic [WIDTH-1:0]   dividend_i,
`endif
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               neg_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] mul_fixed;

  always_comb begin
    mul_fixed = neg_i ? -prod_i : prod_i;
    hi_o      = mul_fixed[2*WIDTH-1:WIDTH];
    lo_o      = mul_fixed[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_i) begin
      // Divide by zero bypasses sign correction and returns the raw dividend in HI
      if (div0_i) begin
        hi_o = dividend_i;
        lo_o = '1;
      end else begin
        hi_o = rem_neg_i ? -prod_i[2*WIDTH-1:WIDTH] : prod_i[2*WIDTH-1:WIDTH];
        lo_o = neg_i     ? -prod_i[WIDTH-1:0]       : prod_i[WIDTH-1:0];
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers; one datapath step per cycle.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise divide ops are ignored.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic        clk_i,
  input logic        rst_i,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               res_neg_q, res_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
`endif

  logic               legal_op;
  logic               accept;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MULDIV_DIV_EN
  assign legal_op = 1'b1;
`else
  assign legal_op = ~op_is_div(bus.op);
`endif

  assign accept = (state_q == IDLE) & bus.start & legal_op & ~bus.flush;

  assign rs_neg = op_is_signed(bus.op) & bus.rs[WIDTH-1];
  assign rt_neg = op_is_signed(bus.op) & bus.rt[WIDTH-1];
  assign rs_mag = rs_neg ? -bus.rs : bus.rs;
  assign rt_mag = rt_neg ? -bus.rt : bus.rt;

  // Shift-add: multiplier sits in the low half and drains out as the product shifts in
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // Restoring divide: {remainder, quotient} shifts left, quotient bits enter at bit 0
  assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, mcand_q};
  assign div_ge   = rem_sh >= {1'b0, mcand_q};
  assign div_next = div_ge ? {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0],   prod_q[WIDTH-2:0], 1'b0};
  assign step_next = is_div_q ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
`ifdef MULDIV_DIV_EN
    .is_div_i   (is_div_q),
    .rem_neg_i  (rem_neg_q),
    .div0_i     (div0_q),
    .dividend_i (dividend_q),
`endif
    .prod_i     (prod_q),
    .neg_i      (res_neg_q),
    .hi_o       (fix_hi),
    .lo_o       (fix_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    res_neg_d = res_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
    dividend_d = dividend_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          cnt_d     = '0;
          prod_d    = {{WIDTH{1'b0}}, rs_mag};
          mcand_d   = rt_mag;
          res_neg_d = rs_neg ^ rt_neg;
`ifdef MULDIV_DIV_EN
          is_div_d   = op_is_div(bus.op);
          rem_neg_d  = rs_neg;
          div0_d     = (bus.rt == '0);
          dividend_d = bus.rs;
`endif
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          prod_d = step_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      res_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      res_neg_q <= res_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
      dividend_q <= dividend_d;
`endif
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  // Covers the issue cycle so a dependent HI/LO read in ID is held
  assign bus.stall = (bus.start & legal_op) | (state_q != IDLE);

endmodule
